// File: rtl/pla_pkg.sv
// Shared types and helpers for the PLA OR-plane block.
package pla_pkg;

    // Commit FSM: accept row writes in StIdle, copy shadow to active in StCommit.
    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StCommit = 1'b1
    } pla_state_e;

    // Row-address width; a single-row plane still needs one address bit.
    function automatic int unsigned addr_w(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pla_or_plane_if.sv
// Row-configuration channel of the OR plane: valid/ready row writes plus commit.
interface pla_or_plane_if
    import pla_pkg::*;
#(
    parameter int unsigned NUM_TERMS = 5,
    parameter int unsigned ADDR_W    = addr_w(4)
) ();

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [NUM_TERMS-1:0] cfg_data;
    logic                 cfg_commit;
    logic                 commit_done;
    logic                 cfg_err;

    // Configuring agent.
    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        output cfg_commit,
        input  cfg_ready,
        input  commit_done,
        input  cfg_err
    );

    // OR plane.
    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_commit,
        output cfg_ready,
        output commit_done,
        output cfg_err
    );

endinterface

// File: rtl/pla_or_row.sv
// One OR-plane row: OR of the product terms selected by this row's mask.
module pla_or_row #(
    parameter int unsigned NUM_TERMS = 5
) (
    input  logic [NUM_TERMS-1:0] terms_i,
    input  logic [NUM_TERMS-1:0] mask_i,
    output logic                 y_o
);

    // An all-zero mask selects nothing and yields 0.
    always_comb begin
        y_o = |(terms_i & mask_i);
    end

endmodule

// File: rtl/pla_or_plane.sv
// PLA OR plane with double-buffered row masks. Rows are written into a shadow
// bank and become visible only when a commit copies the whole bank to active.
module pla_or_plane
    import pla_pkg::*;
#(
    parameter int unsigned          NUM_TERMS   = 5,
    parameter int unsigned          NUM_OUTPUTS = 4,
    parameter logic [NUM_TERMS-1:0] INIT_ROW    = NUM_TERMS'(3),
    parameter bit                   REG_OUT     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_TERMS-1:0]   terms,
    output logic [NUM_OUTPUTS-1:0] y,
    pla_or_plane_if.slave          cfg
);

    localparam int unsigned ADDR_W = addr_w(NUM_OUTPUTS);

    typedef logic [NUM_OUTPUTS-1:0][NUM_TERMS-1:0] bank_t;

    pla_state_e state_q, state_d;
    bank_t      shadow_q, shadow_d;
    bank_t      active_q, active_d;
    logic       dirty_q, dirty_d;
    logic       commit_done_q, commit_done_d;
    logic       cfg_err_q, cfg_err_d;

    logic [ADDR_W-1:0]      addr;
    logic                   addr_ok;
    logic                   wr_accept;
    logic [NUM_OUTPUTS-1:0] y_c;

    assign addr = cfg.cfg_addr;

    // Ready only in IDLE and never while reset is held.
    always_comb begin
        cfg.cfg_ready = rst_n && (state_q == StIdle);
        wr_accept     = cfg.cfg_valid && cfg.cfg_ready;
        addr_ok       = (32'(addr) < NUM_OUTPUTS);
    end

    assign cfg.commit_done = commit_done_q;
    assign cfg.cfg_err     = cfg_err_q;

    // Next-state logic for the commit FSM and both mask banks.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        dirty_d       = dirty_q;
        commit_done_d = 1'b0;
        cfg_err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (wr_accept) begin
                    if (addr_ok) begin
                        // Loop compare keeps the write in range for any row count.
                        for (int j = 0; j < int'(NUM_OUTPUTS); j++) begin
                            if (addr == ADDR_W'(j)) begin
                                shadow_d[j] = cfg.cfg_data;
                            end
                        end
                        dirty_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                // A same-cycle write lands in shadow_q before the copy edge.
                if (cfg.cfg_commit && (dirty_q || (wr_accept && addr_ok))) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                active_d      = shadow_q;
                dirty_d       = 1'b0;
                commit_done_d = 1'b1;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts a pending copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            shadow_q      <= {NUM_OUTPUTS{INIT_ROW}};
            active_q      <= {NUM_OUTPUTS{INIT_ROW}};
            dirty_q       <= 1'b0;
            commit_done_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    for (genvar j = 0; j < int'(NUM_OUTPUTS); j++) begin : g_row
        pla_or_row #(
            .NUM_TERMS (NUM_TERMS)
        ) u_row (
            .terms_i (terms),
            .mask_i  (active_q[j]),
            .y_o     (y_c[j])
        );
    end

    if (REG_OUT) begin : g_reg_out
        logic [NUM_OUTPUTS-1:0] y_q, y_d;

        // Output stage input is the raw OR-plane result.
        always_comb begin
            y_d = y_c;
        end

        // One-cycle output register, cleared by reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                y_q <= '0;
            end else begin
                y_q <= y_d;
            end
        end

        assign y = y_q;
    end else begin : g_comb_out
        assign y = y_c;
    end

endmodule

// File: tb/tb_pla_or_plane.sv
// Directed bench: a default registered-output plane (A) and a 5-row
// combinational-output plane (B); B's 3-bit address can express row 5.
module tb_pla_or_plane;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] terms_a = '0;
    logic [4:0] terms_b = '0;
    logic [3:0] y_a;
    logic [4:0] y_b;

    int n_checks = 0;
    int n_pass   = 0;

    pla_or_plane_if #(.NUM_TERMS(5), .ADDR_W(2)) if_a ();
    pla_or_plane_if #(.NUM_TERMS(5), .ADDR_W(3)) if_b ();

    pla_or_plane #(
        .NUM_TERMS   (5),
        .NUM_OUTPUTS (4),
        .INIT_ROW    (5'b00011),
        .REG_OUT     (1'b1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .terms (terms_a),
        .y     (y_a),
        .cfg   (if_a.slave)
    );

    pla_or_plane #(
        .NUM_TERMS   (5),
        .NUM_OUTPUTS (5),
        .INIT_ROW    (5'b00011),
        .REG_OUT     (1'b0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .terms (terms_b),
        .y     (y_b),
        .cfg   (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        if_a.cfg_valid = 1'b0; if_a.cfg_addr = '0; if_a.cfg_data = '0; if_a.cfg_commit = 1'b0;
        if_b.cfg_valid = 1'b0; if_b.cfg_addr = '0; if_b.cfg_data = '0; if_b.cfg_commit = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready_a", 32'(if_a.cfg_ready), 32'd0);
        check("rst_ready_b", 32'(if_b.cfg_ready), 32'd0);
        check("rst_y_a", 32'(y_a), 32'd0);
        check("rst_done_a", 32'(if_a.commit_done), 32'd0);
        check("rst_err_a", 32'(if_a.cfg_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_ready_a", 32'(if_a.cfg_ready), 32'd1);

        // INIT_ROW = 00011 in every row
        terms_a = 5'b00010;
        tick();
        check("init_hit", 32'(y_a), 32'b1111);
        terms_a = 5'b11100;
        tick();
        check("init_miss", 32'(y_a), 32'b0000);

        // Shadow write is invisible until commit
        if_a.cfg_valid = 1'b1; if_a.cfg_addr = 2'd2; if_a.cfg_data = 5'b10000;
        terms_a = 5'b10000;
        tick();
        if_a.cfg_valid = 1'b0;
        check("nocommit_y0", 32'(y_a), 32'b0000);
        tick();
        check("nocommit_y1", 32'(y_a), 32'b0000);
        if_a.cfg_commit = 1'b1;
        tick();
        if_a.cfg_commit = 1'b0;
        check("commit_ready_low", 32'(if_a.cfg_ready), 32'd0);
        check("commit_done_early", 32'(if_a.commit_done), 32'd0);
        tick();
        check("commit_done", 32'(if_a.commit_done), 32'd1);
        check("commit_y_lag", 32'(y_a), 32'b0000);
        tick();
        check("commit_done_once", 32'(if_a.commit_done), 32'd0);
        check("commit_y", 32'(y_a), 32'b0100);

        // Commit with nothing dirty is ignored
        if_a.cfg_commit = 1'b1;
        tick();
        if_a.cfg_commit = 1'b0;
        check("noop_ready", 32'(if_a.cfg_ready), 32'd1);
        tick();
        check("noop_done", 32'(if_a.commit_done), 32'd0);

        // Write and commit in the same cycle
        if_a.cfg_valid = 1'b1; if_a.cfg_addr = 2'd0; if_a.cfg_data = 5'b01000;
        if_a.cfg_commit = 1'b1;
        tick();
        if_a.cfg_valid = 1'b0; if_a.cfg_commit = 1'b0;
        check("wc_ready_low", 32'(if_a.cfg_ready), 32'd0);
        tick();
        check("wc_ready_back", 32'(if_a.cfg_ready), 32'd1);
        check("wc_done", 32'(if_a.commit_done), 32'd1);
        terms_a = 5'b01000;
        tick();
        check("wc_done_once", 32'(if_a.commit_done), 32'd0);
        check("wc_y", 32'(y_a), 32'b0001);

        // Last write to a row wins
        if_a.cfg_valid = 1'b1; if_a.cfg_addr = 2'd1; if_a.cfg_data = 5'b10000;
        tick();
        if_a.cfg_data = 5'b00100;
        tick();
        if_a.cfg_valid = 1'b0;
        if_a.cfg_commit = 1'b1;
        tick();
        if_a.cfg_commit = 1'b0;
        tick();
        terms_a = 5'b00100;
        tick();
        check("lww_new", 32'(y_a), 32'b0010);
        terms_a = 5'b10000;
        tick();
        check("lww_old", 32'(y_a), 32'b0100);

        // Reset during the COMMIT cycle aborts the copy
        if_a.cfg_valid = 1'b1; if_a.cfg_addr = 2'd3; if_a.cfg_data = 5'b00100;
        if_a.cfg_commit = 1'b1;
        tick();
        if_a.cfg_valid = 1'b0; if_a.cfg_commit = 1'b0;
        check("abort_in_commit", 32'(if_a.cfg_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check("abort_done_rst", 32'(if_a.commit_done), 32'd0);
        check("abort_y_rst", 32'(y_a), 32'd0);
        check("abort_ready_rst", 32'(if_a.cfg_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 32'(if_a.commit_done), 32'd0);
        terms_a = 5'b00001;
        tick();
        check("abort_init_y", 32'(y_a), 32'b1111);
        terms_a = 5'b10000;
        tick();
        check("abort_row2_init", 32'(y_a), 32'b0000);

        // Plane B: combinational output follows terms in the same cycle
        terms_b = 5'b00010;
        #1;
        check("comb_hit", 32'(y_b), 32'b11111);
        terms_b = 5'b11100;
        #1;
        check("comb_miss", 32'(y_b), 32'b00000);

        // Out-of-range writes are rejected with a one-cycle error pulse
        if_b.cfg_valid = 1'b1; if_b.cfg_addr = 3'd5; if_b.cfg_data = 5'b11100;
        tick();
        if_b.cfg_valid = 1'b0;
        check("err5_pulse", 32'(if_b.cfg_err), 32'd1);
        tick();
        check("err5_clear", 32'(if_b.cfg_err), 32'd0);
        if_b.cfg_valid = 1'b1; if_b.cfg_addr = 3'd7;
        tick();
        if_b.cfg_valid = 1'b0;
        check("err7_pulse", 32'(if_b.cfg_err), 32'd1);
        tick();
        check("err7_clear", 32'(if_b.cfg_err), 32'd0);
        if_b.cfg_commit = 1'b1;
        tick();
        if_b.cfg_commit = 1'b0;
        check("err_noop_ready", 32'(if_b.cfg_ready), 32'd1);
        tick();
        check("err_noop_done", 32'(if_b.commit_done), 32'd0);

        // Commit timing one cycle earlier without the output register
        if_b.cfg_valid = 1'b1; if_b.cfg_addr = 3'd2; if_b.cfg_data = 5'b10000;
        tick();
        if_b.cfg_addr = 3'd4; if_b.cfg_data = 5'b00100;
        tick();
        if_b.cfg_valid = 1'b0;
        if_b.cfg_commit = 1'b1;
        tick();
        if_b.cfg_commit = 1'b0;
        terms_b = 5'b10000;
        #1;
        check("b_commit_ready", 32'(if_b.cfg_ready), 32'd0);
        check("b_commit_old", 32'(y_b), 32'b00000);
        tick();
        check("b_commit_done", 32'(if_b.commit_done), 32'd1);
        check("b_commit_y", 32'(y_b), 32'b00100);
        terms_b = 5'b00100;
        #1;
        check("b_row4", 32'(y_b), 32'b10000);
        // Rows 0,1,3 must still hold INIT_ROW (rejected writes did not leak)
        terms_b = 5'b00011;
        #1;
        check("b_shadow_intact", 32'(y_b), 32'b01011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
